// File: rtl/synaptic_integrator_if.sv
// Bus between the spike/weight source and the synaptic integrator.
// The master drives start, spikes and weight writes; the slave returns the timestep result.
interface synaptic_integrator_if #(
   parameter int NUM_INPUTS = 8,
   parameter int WEIGHT_W   = 8,
   parameter int SUM_W      = 16
);
   localparam int ADDR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic                       start;
   logic [NUM_INPUTS-1:0]      spike_in;
   logic                       w_wr_en;
   logic [ADDR_W-1:0]          w_wr_addr;
   logic signed [WEIGHT_W-1:0] w_wr_data;
   logic                       busy;
   logic signed [SUM_W-1:0]    input_sum;
   logic                       update_enable;
   logic                       sat_flag;

   modport master (
      output start, spike_in, w_wr_en, w_wr_addr, w_wr_data,
      input  busy, input_sum, update_enable, sat_flag
   );

   modport slave (
      input  start, spike_in, w_wr_en, w_wr_addr, w_wr_data,
      output busy, input_sum, update_enable, sat_flag
   );
endinterface

// File: rtl/synaptic_integrator.sv
// Serial weighted spike summation feeding the LIF neuron, one channel per clock,
// with per-addition saturation and a one-cycle update_enable pulse per timestep.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; result and sat_flag held
//   S_ACCUM | adding weight[idx] of each captured spike, idx = 0..N-1
module synaptic_integrator #(
   parameter int NUM_INPUTS = 8,
   parameter int WEIGHT_W   = 8,
   parameter int SUM_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   synaptic_integrator_if.slave bus
);
   localparam int ADDR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);
   localparam logic signed [SUM_W:0] MAX_EXT = {2'b00, {(SUM_W-1){1'b1}}};
   localparam logic signed [SUM_W:0] MIN_EXT = {2'b11, {(SUM_W-1){1'b0}}};

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   state_t                     state_q, state_d;
   logic [NUM_INPUTS-1:0]      spikes_q, spikes_d;
   logic [ADDR_W-1:0]          idx_q, idx_d;
   logic signed [SUM_W-1:0]    acc_q, acc_d;
   logic                       sat_q, sat_d;
   logic signed [SUM_W-1:0]    sum_q, sum_d;
   logic                       sat_flag_q, sat_flag_d;
   logic                       busy_q, busy_d;
   logic                       ue_q, ue_d;
   logic signed [WEIGHT_W-1:0] weight_q [NUM_INPUTS];

   logic signed [WEIGHT_W-1:0] w_rd;
   logic signed [SUM_W:0]      sum_ext;
   logic signed [SUM_W-1:0]    add_val;
   logic                       add_ovf;
   logic signed [SUM_W-1:0]    acc_nxt;
   logic                       sat_nxt;

   // Read port sees the pre-edge weight, so a same-edge write to this channel lands next timestep.
   assign w_rd    = weight_q[idx_q];
   assign sum_ext = {acc_q[SUM_W-1], acc_q}
                  + {{(SUM_W+1-WEIGHT_W){w_rd[WEIGHT_W-1]}}, w_rd};

   always_comb begin
      add_ovf = 1'b0;
      add_val = sum_ext[SUM_W-1:0];
      if (sum_ext > MAX_EXT) begin
         add_ovf = 1'b1;
         add_val = MAX_EXT[SUM_W-1:0];
      end else if (sum_ext < MIN_EXT) begin
         add_ovf = 1'b1;
         add_val = MIN_EXT[SUM_W-1:0];
      end
   end

   always_comb begin
      state_d    = state_q;
      spikes_d   = spikes_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      sat_d      = sat_q;
      sum_d      = sum_q;
      sat_flag_d = sat_flag_q;
      busy_d     = busy_q;
      ue_d       = 1'b0;
      acc_nxt    = acc_q;
      sat_nxt    = sat_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               spikes_d = bus.spike_in;
               acc_d    = '0;
               idx_d    = '0;
               sat_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (spikes_q[idx_q]) begin
               acc_nxt = add_val;
               sat_nxt = sat_q | add_ovf;
            end
            acc_d = acc_nxt;
            sat_d = sat_nxt;
            if (idx_q == LAST_IDX) begin
               sum_d      = acc_nxt;
               sat_flag_d = sat_nxt;
               ue_d       = 1'b1;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         spikes_q   <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         sat_q      <= 1'b0;
         sum_q      <= '0;
         sat_flag_q <= 1'b0;
         busy_q     <= 1'b0;
         ue_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         spikes_q   <= spikes_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         sat_q      <= sat_d;
         sum_q      <= sum_d;
         sat_flag_q <= sat_flag_d;
         busy_q     <= busy_d;
         ue_q       <= ue_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_INPUTS; i++) weight_q[i] <= '0;
      end else if (bus.w_wr_en && (int'(bus.w_wr_addr) < NUM_INPUTS)) begin
         weight_q[bus.w_wr_addr] <= bus.w_wr_data;
      end
   end

   assign bus.busy          = busy_q;
   assign bus.input_sum     = sum_q;
   assign bus.update_enable = ue_q;
   assign bus.sat_flag      = sat_flag_q;
endmodule

// File: tb/tb_synaptic_integrator.sv
// Bench for synaptic_integrator: 16-bit and 9-bit accumulator instances checked against
// a per-channel saturating-sum model, fixed vectors, and timestep corner sequences.
module tb_synaptic_integrator;
   localparam int N   = 8;
   localparam int CYC = 24;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   synaptic_integrator_if #(.NUM_INPUTS(N), .WEIGHT_W(8), .SUM_W(16)) if16 ();
   synaptic_integrator_if #(.NUM_INPUTS(N), .WEIGHT_W(8), .SUM_W(9))  if9  ();

   synaptic_integrator #(.NUM_INPUTS(N), .WEIGHT_W(8), .SUM_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(if16));
   synaptic_integrator #(.NUM_INPUTS(N), .WEIGHT_W(8), .SUM_W(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .bus(if9));

   int n_pass = 0;
   int n_total = 0;
   int w16 [N];
   int w9  [N];

   int ue_n, busy_n, end_sum, end_sat;
   int ue_c [2];
   int ue_sum [2];
   int ue_sat [2];

   typedef struct {
      logic [7:0] sp;
      int         exp_sum;
      int         exp_sat;
   } vec_t;
   vec_t tab [6];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive_in(input int sel, input logic st, input logic [7:0] sp,
                           input logic we, input int wa, input int wd);
      if (sel == 0) begin
         if16.start = st; if16.spike_in = sp; if16.w_wr_en = we;
         if16.w_wr_addr = 3'(wa); if16.w_wr_data = 8'(wd);
      end else begin
         if9.start = st; if9.spike_in = sp; if9.w_wr_en = we;
         if9.w_wr_addr = 3'(wa); if9.w_wr_data = 8'(wd);
      end
   endtask

   task automatic sample(input int sel, output logic b, output logic u,
                         output int s, output logic st);
      if (sel == 0) begin
         b = if16.busy; u = if16.update_enable; s = int'(if16.input_sum); st = if16.sat_flag;
      end else begin
         b = if9.busy; u = if9.update_enable; s = int'(if9.input_sum); st = if9.sat_flag;
      end
   endtask

   task automatic wr_w(input int sel, input int addr, input int data);
      drive_in(sel, 1'b0, 8'h00, 1'b1, addr, data);
      @(posedge clk); #1;
      drive_in(sel, 1'b0, 8'h00, 1'b0, 0, 0);
      if (sel == 0) w16[addr] = data; else w9[addr] = data;
   endtask

   // Reference: a write during cycle c lands at edge c+1; channel i is read at edge i+1.
   task automatic model_ts(input int sel, input logic [7:0] sp, input int wc, input int wa,
                           input int wd, output int s, output int st);
      int hi, lo, wv;
      hi = (sel == 0) ? 32767 : 255;
      lo = (sel == 0) ? -32768 : -256;
      s  = 0;
      st = 0;
      for (int i = 0; i < N; i++) begin
         if (sp[i]) begin
            wv = (sel == 0) ? w16[i] : w9[i];
            if (wc >= 0 && wa == i && wc < i) wv = wd;
            s = s + wv;
            if (s > hi) begin s = hi; st = 1; end
            else if (s < lo) begin s = lo; st = 1; end
         end
      end
   endtask

   // Called #1 after a clock edge; start is sampled at the next edge (cycle 0 follows it).
   task automatic run_ts(input int sel, input logic [7:0] sp, input logic [7:0] sp2,
                         input logic [31:0] smask, input int wc, input int wa, input int wd);
      logic b, u, st;
      int   s;
      drive_in(sel, 1'b1, sp, 1'b0, 0, 0);
      @(posedge clk); #1;
      ue_n = 0; busy_n = 0;
      ue_c[0] = -1; ue_c[1] = -1;
      for (int c = 0; c < CYC; c++) begin
         sample(sel, b, u, s, st);
         if (b) busy_n++;
         if (u) begin
            if (ue_n < 2) begin
               ue_c[ue_n] = c; ue_sum[ue_n] = s; ue_sat[ue_n] = int'(st);
            end
            ue_n++;
         end
         end_sum = s;
         end_sat = int'(st);
         drive_in(sel, smask[c], smask[c] ? sp2 : 8'($urandom), c == wc, wa, wd);
         @(posedge clk); #1;
      end
      drive_in(sel, 1'b0, 8'h00, 1'b0, 0, 0);
      if (wc >= 0) begin
         if (sel == 0) w16[wa] = wd; else w9[wa] = wd;
      end
   endtask

   task automatic check_single(input string name, input int exp_sum, input int exp_sat);
      check({name, "_ue_count"}, ue_n, 1);
      check({name, "_ue_cycle"}, ue_c[0], 8);
      check({name, "_busy_cycles"}, busy_n, 8);
      check({name, "_sum"}, ue_sum[0], exp_sum);
      check({name, "_sat"}, ue_sat[0], exp_sat);
      check({name, "_held_sum"}, end_sum, exp_sum);
      check({name, "_held_sat"}, end_sat, exp_sat);
   endtask

   initial begin
      int sel, wc, wa, wd, es, est, seen_ue;
      logic [7:0] sp;

      for (int i = 0; i < N; i++) begin w16[i] = 0; w9[i] = 0; end
      drive_in(0, 1'b0, 8'h00, 1'b0, 0, 0);
      drive_in(1, 1'b0, 8'h00, 1'b0, 0, 0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      check("rst_busy", int'(if16.busy), 0);
      check("rst_ue", int'(if16.update_enable), 0);
      check("rst_sum", int'(if16.input_sum), 0);
      check("rst_sat", int'(if16.sat_flag), 0);
      check("rst_sum9", int'(if9.input_sum), 0);

      run_ts(0, 8'hFF, 8'h00, 32'h0, -1, 0, 0);
      check_single("t1_zero_w", 0, 0);

      for (int i = 0; i < N; i++) wr_w(0, i, 10 * (i + 1));
      tab[0] = '{8'hA5, 180, 0};
      tab[1] = '{8'h00, 0, 0};
      tab[2] = '{8'hFF, 360, 0};
      tab[3] = '{8'h01, 10, 0};
      tab[4] = '{8'h80, 80, 0};
      tab[5] = '{8'h3C, 180, 0};
      for (int i = 0; i < 6; i++) begin
         run_ts(0, tab[i].sp, 8'h00, 32'h0, -1, 0, 0);
         check_single($sformatf("tab%0d", i), tab[i].exp_sum, tab[i].exp_sat);
      end

      for (int i = 0; i < N; i++) wr_w(1, i, 127);
      run_ts(1, 8'hFF, 8'h00, 32'h0, -1, 0, 0);
      check_single("t3_sat_hi", 255, 1);
      wr_w(1, 7, -128);
      run_ts(1, 8'hFF, 8'h00, 32'h0, -1, 0, 0);
      check_single("t3_pull_down", 127, 1);

      run_ts(0, 8'hA5, 8'hFF, (32'h1 << 3) | (32'h1 << 5), -1, 0, 0);
      check_single("t4_ignore", 180, 0);
      run_ts(0, 8'hA5, 8'h0F, 32'h1 << 8, -1, 0, 0);
      check("t4_b2b_ue_count", ue_n, 2);
      check("t4_b2b_first_cycle", ue_c[0], 8);
      check("t4_b2b_first_sum", ue_sum[0], 180);
      check("t4_b2b_second_cycle", ue_c[1], 17);
      check("t4_b2b_second_sum", ue_sum[1], 100);
      check("t4_b2b_busy_cycles", busy_n, 16);
      check("t4_b2b_held_sum", end_sum, 100);

      run_ts(0, 8'h05, 8'h00, 32'h0, 2, 2, -50);
      check_single("t5_same_edge_old", 40, 0);
      run_ts(0, 8'h05, 8'h00, 32'h0, -1, 0, 0);
      check_single("t5_next_new", -40, 0);
      run_ts(0, 8'h41, 8'h00, 32'h0, 2, 6, -7);
      check_single("t5_ahead_applies", 3, 0);
      run_ts(0, 8'h41, 8'h00, 32'h0, 5, 0, 99);
      check_single("t5_behind_deferred", 3, 0);
      run_ts(0, 8'h41, 8'h00, 32'h0, -1, 0, 0);
      check_single("t5_behind_next", 92, 0);

      drive_in(0, 1'b1, 8'hFF, 1'b0, 0, 0);
      @(posedge clk); #1;
      drive_in(0, 1'b0, 8'h00, 1'b0, 0, 0);
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("t6_busy", int'(if16.busy), 0);
      check("t6_sum", int'(if16.input_sum), 0);
      check("t6_ue", int'(if16.update_enable), 0);
      check("t6_sat9", int'(if9.sat_flag), 0);
      check("t6_sum9", int'(if9.input_sum), 0);
      seen_ue = 0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin w16[i] = 0; w9[i] = 0; end
      repeat (12) begin
         if (if16.update_enable) seen_ue++;
         @(posedge clk); #1;
      end
      check("t6_no_ue", seen_ue, 0);
      run_ts(0, 8'hFF, 8'h00, 32'h0, -1, 0, 0);
      check_single("t6_weights_zero", 0, 0);
      wr_w(0, 3, 5);
      run_ts(0, 8'h08, 8'h00, 32'h0, -1, 0, 0);
      check_single("t6_fresh", 5, 0);

      for (int s2 = 0; s2 < 2; s2++)
         for (int i = 0; i < N; i++) wr_w(s2, i, int'($urandom_range(0, 255)) - 128);
      for (int it = 0; it < 24; it++) begin
         sel = it % 2;
         if ($urandom_range(0, 2) == 0)
            wr_w(sel, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
         sp = 8'($urandom);
         wc = int'($urandom_range(0, 8)) - 1;
         wa = int'($urandom_range(0, 7));
         wd = int'($urandom_range(0, 255)) - 128;
         model_ts(sel, sp, wc, wa, wd, es, est);
         run_ts(sel, sp, 8'h00, 32'h0, wc, wa, wd);
         check_single($sformatf("rnd%0d", it), es, est);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
